uart_tx_interface: RTL
======================

UART_TX_INTERFACE -- requirements
Module: uart_tx_interface

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 ready  output  1  bus responder can accept a request this cycle.
REQ-007 addr  input  1  register select: 0 = TXDATA, 1 = STATUS.
REQ-008 write_data  input  32  write payload; only [7:0] used.
REQ-009 byte_enable  input  4  byte lanes; only bit 0 used.
REQ-010 write_req  input  1  write request, valid only while ready=1.
REQ-011 read_req  input  1  read request, valid only while ready=1.
REQ-012 read_data  output  32  read response data.
REQ-013 read_data_valid  output  1  one-cycle pulse qualifying read_data.
REQ-014 tx  output  1  serial line, idle high.

Function
REQ-015 SHALL accept a request only at a rising edge where ready=1 and write_req or read_req is high; requests with ready=0 SHALL be ignored with no side effects.
REQ-016 SHALL drive ready = 0 when FIFO count == FIFO_DEPTH, else 1 (combinational from registered count).
REQ-017 Write to addr 0 with byte_enable[0]=1 SHALL push write_data[7:0] into the FIFO; byte_enable[0]=0 SHALL discard the write.
REQ-018 Write to addr 1 SHALL be discarded with no state change.
REQ-019 Accepted read SHALL assert read_data_valid for exactly one cycle, on the cycle after the accepting edge, with read_data registered in the same cycle.
REQ-020 Read of addr 1 SHALL return {26'b0, count[4:0], busy} where busy=1 when the FSM is not IDLE; count is the FIFO occupancy sampled at the accepting edge.
REQ-021 Read of addr 0 SHALL return 32'h0.
REQ-022 read_data SHALL hold its last value when read_data_valid=0.
REQ-023 Simultaneous write_req and read_req SHALL perform both; the read returns pre-write status.
REQ-024 FIFO SHALL be first-in first-out; pointers wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave count unchanged.
REQ-025 Transmit FSM states: IDLE, START, DATA, STOP.
REQ-026 IDLE: tx=1; if count>0 at an edge, pop head byte into shift register, clear baud counter and bit index, go to START.
REQ-027 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-028 DATA: tx=shift[0], LSB first; each bit held CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-029 STOP: tx=1 for CLKS_PER_BIT cycles; then, if count>0, pop and go directly to START (no idle gap), else IDLE.
REQ-030 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; one frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-031 tx SHALL be a registered output (glitch-free).
REQ-032 Write accepted to an empty FIFO with FSM in IDLE SHALL cause tx to go low at the first rising edge after the accepting edge.

Reset
REQ-033 While reset=1 at a rising edge: FIFO emptied (count=0, pointers 0), FSM=IDLE, baud counter and bit index 0, tx=1, read_data=0, read_data_valid=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame, returning tx=1 at the next edge; queued bytes SHALL be lost.
REQ-035 ready SHALL be 1 during and immediately after reset.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-036 Write 0x55 to addr 0 from idle -> tx low 1 edge later; line 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each 4 cycles; 40 cycles total; busy=0 afterwards.
REQ-037 Write 0xA5, 0x3C back-to-back -> two frames with no idle cycle between stop and next start; STATUS read mid-first-frame returns 0x3 (count=1, busy=1).
REQ-038 Write 9 bytes while idle -> ready falls after FIFO reaches 8 entries (first byte popped once); 10th write attempted with ready=0 ignored; all 9 bytes transmitted in order.
REQ-039 Write with byte_enable=4'b1110, and write to addr 1 -> no frame, STATUS reads 0x0.
REQ-040 Assert reset during DATA bit 3 with 2 bytes queued -> tx=1 next edge, STATUS reads 0x0, no further frames.
REQ-041 Simultaneous write 0x01 and STATUS read from empty/idle -> read_data_valid pulse with read_data=0x0; frame for 0x01 follows.

Source files
------------

// File: rtl/uart_tx_interface_if.sv
// Register-bus bundle between a requester and the UART transmitter.
// The master drives requests; the slave answers with ready and read data.
interface uart_tx_interface_if;
  logic        ready;
  logic        addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        write_req;
  logic        read_req;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport master (
    input  ready, read_data, read_data_valid,
    output addr, write_data, byte_enable, write_req, read_req
  );

  modport slave (
    output ready, read_data, read_data_valid,
    input  addr, write_data, byte_enable, write_req, read_req
  );
endinterface

// File: rtl/uart_tx_interface.sv
// UART transmitter (8N1, LSB first) fed by a small byte FIFO behind a
// two-register bus: TXDATA (addr 0, write) and STATUS (addr 1, read).
module uart_tx_interface #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_interface_if.slave  bus,
  output logic                tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [4:0]    DEPTH     = 5'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic [1:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic [31:0]   r_read_data;
  logic          r_read_data_valid;

  logic          w_ready;
  logic          w_push;
  logic          w_rd_acc;
  logic          w_baud_done;
  logic          w_pop;
  logic          w_busy;
  logic [7:0]    w_head;
  logic          w_unused_bits;

  assign w_ready     = (r_count != DEPTH);
  assign w_push      = w_ready & bus.write_req & ~bus.addr & bus.byte_enable[0];
  assign w_rd_acc    = w_ready & bus.read_req;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_busy      = (r_state != S_IDLE);
  assign w_head      = r_mem[r_rd_ptr];
  // A pop happens from IDLE or at the very end of STOP, so frames chain gap-free.
  assign w_pop       = (r_count != 5'd0) &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
  assign w_unused_bits = ^{bus.write_data[31:8], bus.byte_enable[3:1]};

  assign bus.ready           = w_ready;
  assign bus.read_data       = r_read_data;
  assign bus.read_data_valid = r_read_data_valid;
  assign tx                  = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // tx is set together with the state it belongs to, so it is purely registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state   <= S_START;
            r_shift   <= w_head;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b0;
          end else begin
            r_tx <= 1'b1;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_state <= S_DATA;
            r_baud  <= '0;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (w_pop) begin
              r_state   <= S_START;
              r_shift   <= w_head;
              r_bit_idx <= 3'd0;
              r_tx      <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // STATUS reflects the pre-edge occupancy, so a same-cycle write is not yet counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data       <= 32'd0;
      r_read_data_valid <= 1'b0;
    end else if (w_rd_acc) begin
      r_read_data_valid <= 1'b1;
      r_read_data       <= bus.addr ? {26'd0, r_count, w_busy} : 32'd0;
    end else begin
      r_read_data_valid <= 1'b0;
    end
  end

endmodule
